// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory-operation sequencer and the hex display:
// display modes, per-operation stage codes and the sequencer FSM states.
package mem_ctrl_pkg;

  localparam logic [1:0] CLEARMODE = 2'b00;
  localparam logic [1:0] READMODE  = 2'b01;
  localparam logic [1:0] WRITEMODE = 2'b10;
  localparam logic [1:0] IDLEMODE  = 2'b11;

  localparam logic [1:0] STAGE_BANNER = 2'b00;
  localparam logic [1:0] STAGE_ADDR   = 2'b01;
  localparam logic [1:0] STAGE_DATA   = 2'b10;
  localparam logic [1:0] STAGE_SHOW   = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_BANNER   = 3'd1;
  localparam state_t S_ADDR     = 3'd2;
  localparam state_t S_DATA     = 3'd3;
  localparam state_t S_RD_ISSUE = 3'd4;
  localparam state_t S_RD_WAIT  = 3'd5;
  localparam state_t S_SHOW     = 3'd6;
  localparam state_t S_CLEAR    = 3'd7;

endpackage

// File: rtl/mem_op_sequencer_if.sv
// Single-port memory bus between the sequencer (master) and the memory (slave).
// Read data is valid exactly one cycle after memRe.
interface mem_op_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memWe;
  logic              memRe;
  logic [DATA_W-1:0] memRdata;

  modport master (
    output memAddr, memWdata, memWe, memRe,
    input  memRdata
  );

  modport slave (
    input  memAddr, memWdata, memWe, memRe,
    output memRdata
  );
endinterface

// File: rtl/mem_op_sequencer_clear_counter.sv
// Address counter for the clear sweep: loads zero on start, counts up on enable
// and stops at all-ones; count_next exposes the value the counter takes this edge.
module clear_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] count_next,
  output logic              tc
);

  logic [ADDR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign tc         = &count_q;

endmodule

// File: rtl/mem_op_sequencer.sv
// Operator-driven clear/read/write sequencer for a single-port memory; also drives
// the mode, stage and value inputs of the hex display. All outputs are registered.
module mem_op_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        modeSw,
  input  logic [DATA_W-1:0] sw,
  input  logic              go,
  input  logic              abort,
  mem_op_sequencer_if.master mem,
  output logic [1:0]        modeSelect,
  output logic [1:0]        stage,
  output logic [DATA_W-1:0] dispVal,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_reg_q, addr_reg_d;
  logic [DATA_W-1:0] data_reg_q, data_reg_d;

  logic [1:0]        mode_select_q, mode_select_d;
  logic [1:0]        stage_q, stage_d;
  logic [DATA_W-1:0] disp_val_q, disp_val_d;
  logic              busy_q, busy_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              cnt_start, cnt_en, cnt_tc;
  logic [ADDR_W-1:0] cnt_value, cnt_next;

  clear_counter #(.ADDR_W(ADDR_W)) u_clear_counter (
    .clk        (clk),
    .rst        (rst),
    .start      (cnt_start),
    .en         (cnt_en),
    .count      (cnt_value),
    .count_next (cnt_next),
    .tc         (cnt_tc)
  );

  // Next-state and register latching; abort overrides every transition including go.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_reg_d = addr_reg_q;
    data_reg_d = data_reg_q;
    cnt_start  = 1'b0;
    cnt_en     = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (modeSw == CLEARMODE) begin
              state_d   = S_CLEAR;
              cnt_start = 1'b1;
            end else if (modeSw != IDLEMODE) begin
              mode_d  = modeSw;
              state_d = S_BANNER;
            end
          end
        end
        S_BANNER: if (go) state_d = S_ADDR;
        S_ADDR: begin
          if (go) begin
            addr_reg_d = sw[ADDR_W-1:0];
            state_d    = (mode_q == READMODE) ? S_RD_ISSUE : S_DATA;
          end
        end
        S_DATA: begin
          if (go) begin
            data_reg_d  = sw;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_reg_q;
            mem_wdata_d = sw;
            state_d     = S_SHOW;
          end
        end
        S_RD_ISSUE: state_d = S_RD_WAIT;
        S_RD_WAIT: begin
          data_reg_d = mem.memRdata;
          state_d    = S_SHOW;
        end
        S_SHOW: if (go) state_d = S_ADDR;
        S_CLEAR: begin
          if (cnt_tc) begin
            state_d = S_IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    mode_select_d = mode_d;
    stage_d       = stage_q;
    disp_val_d    = disp_val_q;
    busy_d        = (state_d != S_IDLE);
    mem_re_d      = 1'b0;

    case (state_d)
      S_IDLE: begin
        mode_select_d = IDLEMODE;
        stage_d       = STAGE_BANNER;
      end
      S_BANNER: stage_d = STAGE_BANNER;
      S_ADDR: begin
        stage_d    = STAGE_ADDR;
        disp_val_d = sw;
      end
      S_DATA: begin
        stage_d    = STAGE_DATA;
        disp_val_d = sw;
      end
      S_RD_ISSUE, S_RD_WAIT: stage_d = STAGE_DATA;
      S_SHOW: begin
        stage_d    = STAGE_SHOW;
        disp_val_d = data_reg_d;
      end
      S_CLEAR: begin
        mode_select_d = CLEARMODE;
        stage_d       = STAGE_BANNER;
      end
      default: mode_select_d = IDLEMODE;
    endcase
  end

  // Memory strobes for the read issue and the clear sweep.
  logic              strobe_we, strobe_re;
  logic [ADDR_W-1:0] strobe_addr;
  logic [DATA_W-1:0] strobe_wdata;

  always_comb begin
    strobe_we    = mem_we_d;
    strobe_re    = mem_re_d;
    strobe_addr  = mem_addr_d;
    strobe_wdata = mem_wdata_d;
    if (state_d == S_RD_ISSUE) begin
      strobe_re   = 1'b1;
      strobe_addr = addr_reg_d;
    end else if (state_d == S_CLEAR) begin
      strobe_we    = 1'b1;
      strobe_addr  = cnt_next;
      strobe_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= IDLEMODE;
      addr_reg_q    <= '0;
      data_reg_q    <= '0;
      mode_select_q <= IDLEMODE;
      stage_q       <= STAGE_BANNER;
      disp_val_q    <= '0;
      busy_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      addr_reg_q    <= addr_reg_d;
      data_reg_q    <= data_reg_d;
      mode_select_q <= mode_select_d;
      stage_q       <= stage_d;
      disp_val_q    <= disp_val_d;
      busy_q        <= busy_d;
      mem_we_q      <= strobe_we;
      mem_re_q      <= strobe_re;
      mem_addr_q    <= strobe_addr;
      mem_wdata_q   <= strobe_wdata;
    end
  end

  assign mem.memAddr  = mem_addr_q;
  assign mem.memWdata = mem_wdata_q;
  assign mem.memWe    = mem_we_q;
  assign mem.memRe    = mem_re_q;
  assign modeSelect   = mode_select_q;
  assign stage        = stage_q;
  assign dispVal      = disp_val_q;
  assign busy         = busy_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed bench for mem_op_sequencer with a 256x16 memory model (1-cycle read latency).
module tb_mem_op_sequencer;
  import mem_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  modeSw;
  logic [15:0] sw;
  logic        go;
  logic        abort;
  logic [1:0]  modeSelect;
  logic [1:0]  stage;
  logic [15:0] dispVal;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_op_sequencer_if #(.ADDR_W(8), .DATA_W(16)) mif ();

  mem_op_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .modeSw     (modeSw),
    .sw         (sw),
    .go         (go),
    .abort      (abort),
    .mem        (mif.master),
    .modeSelect (modeSelect),
    .stage      (stage),
    .dispVal    (dispVal),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(int a);
    return 16'h5A00 + 16'(a);
  endfunction

  // Memory model: fill_req preloads a known pattern; writes/reads are counted.
  logic [15:0] mem [256];
  logic        fill_req;
  int          we_cnt = 0;
  int          re_cnt = 0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (mif.memWe) begin
      mem[mif.memAddr] <= mif.memWdata;
      we_cnt <= we_cnt + 1;
    end
    if (mif.memRe) begin
      mif.memRdata <= mem[mif.memAddr];
      re_cnt <= re_cnt + 1;
    end
  end

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (modeSelect !== 2'b11) begin errors++; $display("FAIL reset_modeSelect got=%b exp=11", modeSelect); end
    checks++; if (stage !== 2'b00) begin errors++; $display("FAIL reset_stage got=%b exp=00", stage); end
    checks++; if (dispVal !== 16'h0000) begin errors++; $display("FAIL reset_dispVal got=%h exp=0000", dispVal); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mif.memWe !== 1'b0 || mif.memRe !== 1'b0) begin errors++; $display("FAIL reset_strobes got we=%b re=%b exp=0/0", mif.memWe, mif.memRe); end
    checks++; if (mif.memAddr !== 8'h00 || mif.memWdata !== 16'h0000) begin errors++; $display("FAIL reset_bus got addr=%h wdata=%h exp=00/0000", mif.memAddr, mif.memWdata); end
  endtask

  task automatic test_write();
    int base;
    modeSw = WRITEMODE;
    sw = 16'h0000;
    pulse_go();
    checks++; if (modeSelect !== WRITEMODE || stage !== STAGE_BANNER || busy !== 1'b1) begin errors++; $display("FAIL wr_banner got mode=%b stage=%b busy=%b exp=10/00/1", modeSelect, stage, busy); end
    pulse_go();
    checks++; if (stage !== STAGE_ADDR) begin errors++; $display("FAIL wr_addr_stage got=%b exp=01", stage); end
    sw = 16'h0012;
    @(negedge clk);
    checks++; if (dispVal !== 16'h0012) begin errors++; $display("FAIL wr_addr_disp got=%h exp=0012", dispVal); end
    base = we_cnt;
    pulse_go();
    checks++; if (stage !== STAGE_DATA || mif.memWe !== 1'b0) begin errors++; $display("FAIL wr_data_stage got stage=%b we=%b exp=10/0", stage, mif.memWe); end
    sw = 16'hBEEF;
    pulse_go();
    checks++; if (mif.memWe !== 1'b1 || mif.memAddr !== 8'h12 || mif.memWdata !== 16'hBEEF) begin errors++; $display("FAIL wr_strobe got we=%b addr=%h wdata=%h exp=1/12/beef", mif.memWe, mif.memAddr, mif.memWdata); end
    checks++; if (stage !== STAGE_SHOW || dispVal !== 16'hBEEF) begin errors++; $display("FAIL wr_show got stage=%b disp=%h exp=11/beef", stage, dispVal); end
    modeSw = READMODE;
    sw = 16'h0000;
    repeat (3) @(negedge clk);
    checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL wr_we_count got=%0d exp=1", we_cnt - base); end
    checks++; if (mem[8'h12] !== 16'hBEEF) begin errors++; $display("FAIL wr_mem got=%h exp=beef", mem[8'h12]); end
    checks++; if (modeSelect !== WRITEMODE || dispVal !== 16'hBEEF) begin errors++; $display("FAIL wr_mode_sticky got mode=%b disp=%h exp=10/beef", modeSelect, dispVal); end
  endtask

  task automatic test_read();
    int base;
    pulse_abort();
    checks++; if (busy !== 1'b0 || modeSelect !== IDLEMODE) begin errors++; $display("FAIL rd_abort_idle got busy=%b mode=%b exp=0/11", busy, modeSelect); end
    modeSw = READMODE;
    pulse_go();
    checks++; if (modeSelect !== READMODE) begin errors++; $display("FAIL rd_banner got=%b exp=01", modeSelect); end
    pulse_go();
    sw = 16'h0012;
    base = re_cnt;
    pulse_go();
    checks++; if (mif.memRe !== 1'b1 || mif.memAddr !== 8'h12 || stage !== STAGE_DATA) begin errors++; $display("FAIL rd_issue got re=%b addr=%h stage=%b exp=1/12/10", mif.memRe, mif.memAddr, stage); end
    @(negedge clk);
    checks++; if (mif.memRe !== 1'b0 || stage === STAGE_SHOW) begin errors++; $display("FAIL rd_wait got re=%b stage=%b exp=0/not11", mif.memRe, stage); end
    @(negedge clk);
    checks++; if (stage !== STAGE_SHOW || dispVal !== 16'hBEEF) begin errors++; $display("FAIL rd_show got stage=%b disp=%h exp=11/beef", stage, dispVal); end
    checks++; if (re_cnt - base !== 1) begin errors++; $display("FAIL rd_re_count got=%0d exp=1", re_cnt - base); end
    pulse_go();
    checks++; if (stage !== STAGE_ADDR || modeSelect !== READMODE) begin errors++; $display("FAIL rd_repeat got stage=%b mode=%b exp=01/01", stage, modeSelect); end
  endtask

  task automatic test_ignored_mode();
    pulse_abort();
    modeSw = 2'b11;
    pulse_go();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || modeSelect !== IDLEMODE || mif.memWe !== 1'b0) begin errors++; $display("FAIL mode11_ignored got busy=%b mode=%b we=%b exp=0/11/0", busy, modeSelect, mif.memWe); end
  endtask

  task automatic test_abort_data();
    int base;
    modeSw = WRITEMODE;
    pulse_go();
    pulse_go();
    sw = 16'h0034;
    pulse_go();
    base = we_cnt;
    sw = 16'h1111;
    go = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    go = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || mif.memWe !== 1'b0 || modeSelect !== IDLEMODE) begin errors++; $display("FAIL abort_data got busy=%b we=%b mode=%b exp=0/0/11", busy, mif.memWe, modeSelect); end
    repeat (2) @(negedge clk);
    checks++; if (we_cnt !== base || mem[8'h34] !== pat(8'h34)) begin errors++; $display("FAIL abort_data_mem got writes=%0d word=%h exp=0/%h", we_cnt - base, mem[8'h34], pat(8'h34)); end
  endtask

  task automatic test_clear();
    int base;
    int bad;
    modeSw = CLEARMODE;
    base = we_cnt;
    bad = 0;
    pulse_go();
    for (int i = 0; i < 256; i++) begin
      if (!(mif.memWe === 1'b1 && mif.memAddr === 8'(i) && mif.memWdata === 16'h0000 &&
            busy === 1'b1 && modeSelect === CLEARMODE)) bad++;
      if (i == 10) begin go = 1'b1; modeSw = READMODE; end
      if (i == 11) go = 1'b0;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_sweep got bad_cycles=%0d exp=0", bad); end
    checks++; if (busy !== 1'b0 || mif.memWe !== 1'b0 || modeSelect !== IDLEMODE) begin errors++; $display("FAIL clear_end got busy=%b we=%b mode=%b exp=0/0/11", busy, mif.memWe, modeSelect); end
    checks++; if (we_cnt - base !== 256) begin errors++; $display("FAIL clear_count got=%0d exp=256", we_cnt - base); end
    checks++; if (mem[8'h00] !== 16'h0 || mem[8'h12] !== 16'h0 || mem[8'hFF] !== 16'h0) begin errors++; $display("FAIL clear_mem got %h/%h/%h exp=0/0/0", mem[8'h00], mem[8'h12], mem[8'hFF]); end
  endtask

  task automatic test_abort_clear();
    int n;
    int bad;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    modeSw = CLEARMODE;
    pulse_go();
    n = 0;
    while (!(mif.memWe === 1'b1 && mif.memAddr === 8'h7F) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 300) begin errors++; $display("FAIL abort_clear_wait got timeout exp=addr 7f"); end
    pulse_abort();
    checks++; if (busy !== 1'b0 || mif.memWe !== 1'b0) begin errors++; $display("FAIL abort_clear_idle got busy=%b we=%b exp=0/0", busy, mif.memWe); end
    @(negedge clk);
    bad = 0;
    for (int i = 8'h80; i < 256; i++) if (mem[i] !== pat(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_clear_upper got modified=%0d exp=0", bad); end
    checks++; if (mem[8'h00] !== 16'h0 || mem[8'h7F] !== 16'h0) begin errors++; $display("FAIL abort_clear_lower got %h/%h exp=0/0", mem[8'h00], mem[8'h7F]); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    modeSw = CLEARMODE;
    pulse_go();
    n = 0;
    while (!(mif.memWe === 1'b1 && mif.memAddr === 8'h40) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 300) begin errors++; $display("FAIL rstmid_wait got timeout exp=addr 40"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mif.memWe !== 1'b0 || modeSelect !== IDLEMODE || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got we=%b mode=%b busy=%b exp=0/11/0", mif.memWe, modeSelect, busy); end
    checks++; if (mif.memAddr !== 8'h00 || mif.memWdata !== 16'h0 || mif.memRe !== 1'b0) begin errors++; $display("FAIL rstmid_bus got addr=%h wdata=%h re=%b exp=00/0000/0", mif.memAddr, mif.memWdata, mif.memRe); end
    checks++; if (stage !== 2'b00 || dispVal !== 16'h0000) begin errors++; $display("FAIL rstmid_disp got stage=%b disp=%h exp=00/0000", stage, dispVal); end
    @(negedge clk);
    checks++; if (mif.memWe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle got we=%b busy=%b exp=0/0", mif.memWe, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    modeSw = IDLEMODE;
    sw = 16'h0000;
    go = 1'b0;
    abort = 1'b0;
    fill_req = 1'b1;
    repeat (2) @(negedge clk);
    fill_req = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_ignored_mode();
    test_abort_data();
    test_clear();
    test_abort_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
